pixel_op_stream: RTL and testbench

PIXEL_OP_STREAM -- requirements
Module: pixel_op_stream

---
 rtl/pixel_op_pkg.sv | 24 ++
 rtl/pixel_op_lane.sv | 15 +
 rtl/pixel_op_stream.sv | 103 ++++++++++
 tb/tb_pixel_op_stream.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_op_pkg.sv
// pixel_op_pkg: mode encodings and the per-pixel operation shared by the stream and its lanes.
package pixel_op_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_PASS = 2'd0;
    localparam mode_t MODE_INV  = 2'd1;
    localparam mode_t MODE_THR  = 2'd2;
    localparam mode_t MODE_ADD  = 2'd3;

    // Operates on w-bit pixels zero-extended into 32 bits; the add is taken at 33 bits so it can saturate.
    function automatic logic [31:0] lane_op(input mode_t mode, input logic [31:0] x, input logic [31:0] p,
                                            input int w);
        logic [32:0] lim;
        logic [32:0] sum;
        lim = (33'd1 << w) - 33'd1;
        sum = {1'b0, x} + {1'b0, p};
        return mode == MODE_PASS ? x :
               mode == MODE_INV  ? 32'(~{1'b0, x} & lim) :
               mode == MODE_THR  ? (x >= p ? 32'(lim) : 32'd0) :
                                   32'(sum > lim ? lim : sum);
    endfunction

endpackage

// File: rtl/pixel_op_lane.sv
// pixel_op_lane: combinational operation on one pixel lane.
module pixel_op_lane
    import pixel_op_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] param,
    input  logic [PIX_W-1:0] x,
    output logic [PIX_W-1:0] y
);

    assign y = PIX_W'(lane_op(mode, 32'(x), 32'(param), PIX_W));

endmodule

// File: rtl/pixel_op_stream.sv
// pixel_op_stream: two-stage per-lane pixel op pipeline with frame-latched cfg; PIXEL_OP_STATS_EN adds frame_count.
module pixel_op_stream
    import pixel_op_pkg::*;
#(
    parameter int LANES = 4,
    parameter int PIX_W = 8,
    localparam int DATA_WIDTH = LANES * PIX_W
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset,
    input  logic                  s_axis_valid,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_last,
    output logic                  s_axis_ready,
    output logic                  m_axis_valid,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_last,
    input  logic                  m_axis_ready,
    input  logic [1:0]            cfg_mode,
    input  logic [PIX_W-1:0]      cfg_param,
    output logic                  busy
`ifdef PIXEL_OP_STATS_EN
    ,
    output logic [15:0]           frame_count
`endif
);

    logic                  v1_q, v1_d, l1_q, l1_d, v2_q, v2_d, l2_q, l2_d;
    logic [DATA_WIDTH-1:0] d1_q, d1_d, d2_q, d2_d, op_data;
    logic                  busy_q, busy_d;
    logic [1:0]            mode_q, mode_d, eff_mode;
    logic [PIX_W-1:0]      param_q, param_d, eff_param;
    logic                  adv2, acc;

    assign adv2         = !v2_q || m_axis_ready;
    assign s_axis_ready = !axi_reset && (!v1_q || adv2);
    assign acc          = s_axis_valid && s_axis_ready;

    // The first beat of a frame uses the live cfg; later beats use what it latched.
    assign eff_mode  = busy_q ? mode_q : cfg_mode;
    assign eff_param = busy_q ? param_q : cfg_param;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pixel_op_lane #(.PIX_W(PIX_W)) u_lane (
            .mode  (eff_mode),
            .param (eff_param),
            .x     (s_axis_data[i*PIX_W +: PIX_W]),
            .y     (op_data[i*PIX_W +: PIX_W])
        );
    end

    always_comb begin
        v1_d    = acc ? 1'b1 : (adv2 ? 1'b0 : v1_q);
        d1_d    = acc ? op_data : d1_q;
        l1_d    = acc ? s_axis_last : l1_q;
        v2_d    = adv2 ? v1_q : v2_q;
        d2_d    = adv2 && v1_q ? d1_q : d2_q;
        l2_d    = adv2 && v1_q ? l1_q : l2_q;
        busy_d  = acc ? !s_axis_last : busy_q;
        mode_d  = acc && !busy_q ? cfg_mode : mode_q;
        param_d = acc && !busy_q ? cfg_param : param_q;
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            v1_q    <= 1'b0;
            d1_q    <= '0;
            l1_q    <= 1'b0;
            v2_q    <= 1'b0;
            d2_q    <= '0;
            l2_q    <= 1'b0;
            busy_q  <= 1'b0;
            mode_q  <= '0;
            param_q <= '0;
        end else begin
            v1_q    <= v1_d;
            d1_q    <= d1_d;
            l1_q    <= l1_d;
            v2_q    <= v2_d;
            d2_q    <= d2_d;
            l2_q    <= l2_d;
            busy_q  <= busy_d;
            mode_q  <= mode_d;
            param_q <= param_d;
        end
    end

    assign m_axis_valid = v2_q;
    assign m_axis_data  = d2_q;
    assign m_axis_last  = l2_q;
    assign busy         = busy_q;

`ifdef PIXEL_OP_STATS_EN
    logic [15:0] fc_q, fc_d;

    always_comb fc_d = fc_q + 16'(m_axis_valid && m_axis_ready && m_axis_last);

    always_ff @(posedge axi_clk) fc_q <= axi_reset ? 16'd0 : fc_d;

    assign frame_count = fc_q;
`endif

endmodule

// File: tb/tb_pixel_op_stream.sv
// tb_pixel_op_stream: randomized and directed checks of pixel_op_stream against a frame-level reference model.
module tb_pixel_op_stream;

    localparam int LANES = 4;
    localparam int PIX_W = 8;

    logic        axi_clk = 0, axi_reset = 1;
    logic        s_axis_valid = 0, s_axis_last = 0, m_axis_ready = 1;
    logic [31:0] s_axis_data = 0;
    logic [1:0]  cfg_mode = 0;
    logic [7:0]  cfg_param = 0;
    logic        s_axis_ready, m_axis_valid, m_axis_last, busy;
    logic [31:0] m_axis_data;
`ifdef PIXEL_OP_STATS_EN
    logic [15:0] frame_count;
`endif

    pixel_op_stream #(.LANES(LANES), .PIX_W(PIX_W)) dut (
        .axi_clk      (axi_clk),
        .axi_reset    (axi_reset),
        .s_axis_valid (s_axis_valid),
        .s_axis_data  (s_axis_data),
        .s_axis_last  (s_axis_last),
        .s_axis_ready (s_axis_ready),
        .m_axis_valid (m_axis_valid),
        .m_axis_data  (m_axis_data),
        .m_axis_last  (m_axis_last),
        .m_axis_ready (m_axis_ready),
        .cfg_mode     (cfg_mode),
        .cfg_param    (cfg_param),
        .busy         (busy)
`ifdef PIXEL_OP_STATS_EN
        ,
        .frame_count  (frame_count)
`endif
    );

    int errors = 0, checks = 0, cyc = 0, n_in = 0, n_out = 0;
    logic [32:0] exp_q[$];
    logic [31:0] out_log[$];
    bit          m_busy, hold_v, sr_low;
    logic [1:0]  m_mode;
    logic [7:0]  m_param;
    logic [32:0] hold_d;

    always #5 axi_clk = ~axi_clk;
    always @(posedge axi_clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_beat(input logic [31:0] x, input logic [1:0] mode, input logic [7:0] p);
        logic [31:0] r;
        for (int i = 0; i < LANES; i++) begin
            int v, o;
            v = int'(x[i*8 +: 8]);
            o = mode == 0 ? v : mode == 1 ? 255 - v : mode == 2 ? (v >= int'(p) ? 255 : 0)
                              : (v + int'(p) > 255 ? 255 : v + int'(p));
            r[i*8 +: 8] = 8'(o);
        end
        return r;
    endfunction

    // Frame-level model and scoreboard, sampled mid-cycle.
    always @(negedge axi_clk) begin
        if (axi_reset) begin
            exp_q.delete();
            m_busy = 0; m_mode = 0; m_param = 0; hold_v = 0;
        end else begin
            checks++;
            if (busy !== m_busy) begin
                errors++; $display("FAIL busy: got %b expected %b (cyc %0d)", busy, m_busy, cyc);
            end
            if (hold_v) begin
                checks++;
                if (m_axis_valid !== 1'b1 || {m_axis_last, m_axis_data} !== hold_d) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b %h expected v=1 %h (cyc %0d)", m_axis_valid,
                             {m_axis_last, m_axis_data}, hold_d, cyc);
                end
            end
            hold_v = m_axis_valid && !m_axis_ready;
            hold_d = {m_axis_last, m_axis_data};
            if (m_axis_valid && m_axis_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL unexpected_beat: got %h expected none (cyc %0d)", m_axis_data, cyc);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    if ({m_axis_last, m_axis_data} !== e) begin
                        errors++;
                        $display("FAIL beat: got %h expected %h (cyc %0d)", {m_axis_last, m_axis_data}, e, cyc);
                    end
                end
                out_log.push_back(m_axis_data);
                n_out++;
            end
            if (!s_axis_ready) sr_low = 1;
            if (s_axis_valid && s_axis_ready) begin
                if (!m_busy) begin
                    m_mode = cfg_mode; m_param = cfg_param;
                end
                exp_q.push_back({s_axis_last, ref_beat(s_axis_data, m_mode, m_param)});
                m_busy = !s_axis_last;
                n_in++;
            end
        end
    end

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        bit ok;
        ok = 0;
        s_axis_valid = 1; s_axis_data = d; s_axis_last = l;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge axi_clk);
            ok = s_axis_ready;
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL send_timeout: got ready=0 expected ready=1 within 64 cycles");
        end
        tick();
        s_axis_valid = 0;
    endtask

    task automatic drain();
        m_axis_ready = 1;
        for (int n = 0; n < 64 && (exp_q.size() != 0 || m_axis_valid); n++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        axi_reset = 1;
        repeat (2) @(posedge axi_clk);
        @(negedge axi_clk);
        checks += 5;
        if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", m_axis_valid); end
        if (m_axis_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b expected 0", m_axis_last); end
        if (m_axis_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", m_axis_data); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (s_axis_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", s_axis_ready); end
        tick();
        axi_reset = 0;
        @(negedge axi_clk);
        checks++;
        if (s_axis_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst: got %b expected 1", s_axis_ready); end
        tick();
    endtask

    task automatic test_ops();
        logic [1:0]  md[3]   = '{2'd1, 2'd2, 2'd3};
        logic [7:0]  pr[3]   = '{8'h00, 8'h80, 8'h10};
        logic [31:0] din[3]  = '{32'h12345678, 32'h7F80FF00, 32'hF8102000};
        logic [31:0] dout[3] = '{32'hEDCBA987, 32'h00FFFF00, 32'hFF203010};
        m_axis_ready = 1;
        for (int k = 0; k < 3; k++) begin
            cfg_mode = md[k]; cfg_param = pr[k];
            s_axis_valid = 1; s_axis_data = din[k]; s_axis_last = 1;
            @(negedge axi_clk);
            checks++;
            if (s_axis_ready !== 1'b1) begin errors++; $display("FAIL op%0d_ready: got %b expected 1", k, s_axis_ready); end
            tick();
            s_axis_valid = 0;
            @(negedge axi_clk);
            checks++;
            if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL op%0d_early: got valid=%b expected 0", k, m_axis_valid); end
            tick();
            @(negedge axi_clk);
            checks++;
            if (m_axis_valid !== 1'b1 || m_axis_data !== dout[k] || m_axis_last !== 1'b1) begin
                errors++;
                $display("FAIL op%0d_result: got v=%b %h last=%b expected v=1 %h last=1", k, m_axis_valid,
                         m_axis_data, m_axis_last, dout[k]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int t0, o0;
        cfg_mode = 2'(($urandom)); cfg_param = 8'($urandom);
        m_axis_ready = 1;
        t0 = cyc;
        for (int i = 0; i < 8; i++) send($urandom, i == 7);
        checks++;
        if (cyc - t0 != 8) begin errors++; $display("FAIL throughput: got %0d cycles expected 8", cyc - t0); end
        drain();
        sr_low = 0;
        o0 = n_out;
        fork
            for (int i = 0; i < 8; i++) send($urandom, i == 7);
            begin
                repeat (2) @(posedge axi_clk);
                #1 m_axis_ready = 0;
                repeat (3) @(posedge axi_clk);
                #1 m_axis_ready = 1;
            end
        join
        drain();
        checks += 2;
        if (sr_low !== 1'b1) begin errors++; $display("FAIL stall_backpressure: got ready_low=%b expected 1", sr_low); end
        if (n_out - o0 != 8) begin errors++; $display("FAIL stall_count: got %0d expected 8", n_out - o0); end
    endtask

    task automatic test_cfg_latch();
        logic [31:0] d[4];
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        out_log.delete();
        m_axis_ready = 1;
        cfg_mode = 2'd1; cfg_param = 8'h00;
        send(d[0], 0);
        cfg_mode = 2'd0;
        send(d[1], 0);
        send(d[2], 1);
        send(d[3], 1);
        drain();
        checks++;
        if (out_log.size() != 4) begin
            errors++; $display("FAIL latch_count: got %0d expected 4", out_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                logic [31:0] e;
                e = i < 3 ? ~d[i] : d[i];
                checks++;
                if (out_log[i] !== e) begin errors++; $display("FAIL latch_beat%0d: got %h expected %h", i, out_log[i], e); end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] c;
        m_axis_ready = 0;
        cfg_mode = 2'd1;
        send($urandom, 0);
        send($urandom, 0);
        axi_reset = 1;
        tick();
        axi_reset = 0;
        @(negedge axi_clk);
        checks += 2;
        if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", m_axis_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        tick();
        m_axis_ready = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge axi_clk);
            checks++;
            if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL stale_beat: got valid=%b expected 0", m_axis_valid); end
            tick();
        end
        out_log.delete();
        c = $urandom;
        cfg_mode = 2'd0;
        send(c, 1);
        drain();
        checks++;
        if (out_log.size() != 1 || out_log[0] !== c) begin
            errors++; $display("FAIL post_rst_frame: got %0d beats first=%h expected 1 beat %h", out_log.size(),
                               out_log.size() ? out_log[0] : 32'h0, c);
        end
    endtask

    task automatic test_random();
        bit done;
        int i0;
        done = 0;
        i0 = n_in - n_out;
        fork
            begin
                for (int f = 0; f < 25; f++) begin
                    int len;
                    len = $urandom_range(6, 1);
                    for (int b = 0; b < len; b++) begin
                        cfg_mode = 2'($urandom); cfg_param = 8'($urandom);
                        if ($urandom_range(3) == 0) tick();
                        send($urandom, b == len - 1);
                    end
                end
                done = 1;
            end
            while (!done) begin
                tick();
                m_axis_ready = $urandom_range(3) != 0;
            end
        join
        drain();
        checks++;
        if (n_in - n_out != i0) begin errors++; $display("FAIL random_count: got %0d in %0d out", n_in, n_out); end
    endtask

`ifdef PIXEL_OP_STATS_EN
    task automatic test_stats();
        axi_reset = 1;
        tick();
        axi_reset = 0;
        @(negedge axi_clk);
        checks++;
        if (frame_count !== 16'd0) begin errors++; $display("FAIL fc_reset: got %h expected 0", frame_count); end
        tick();
        for (int f = 0; f < 3; f++) begin
            send($urandom, 0);
            send($urandom, 1);
        end
        drain();
        checks++;
        if (frame_count !== 16'd3) begin errors++; $display("FAIL fc_three: got %h expected 3", frame_count); end
        force dut.fc_q = 16'hFFFF;
        @(negedge axi_clk);
        release dut.fc_q;
        tick();
        send($urandom, 1);
        drain();
        checks++;
        if (frame_count !== 16'h0000) begin errors++; $display("FAIL fc_wrap: got %h expected 0000", frame_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_ops();
        test_back_to_back();
        test_cfg_latch();
        test_mid_reset();
        test_random();
`ifdef PIXEL_OP_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
